fpu_cvt_result_retire: RTL and testbench
========================================

// Module: fpu_cvt_result_retire
// PURPOSE
//  Consumer side of the FPU convert unit's result pulse. Captures each single-cycle result (o_valid,
//  fp/int data, is_fp_to_int, flags, rd) into an in-order buffer, since the producer cannot be
//  stalled. Retires results to the int or FP writeback port over valid/ready, reports fflags on retire.
//  Back-pressures the convert unit's start via o_hold. Sits between fpu_convert_unit and WB arbiter.
// PARAMETERS
//  XLEN        32  integer result width
//  FP_WIDTH_D  64  FP result width (NaN-boxed singles already applied upstream)
//  DEPTH       2   buffer entries, power of two, >=2
// PORTS
//  i_clk           in   1                clock
//  i_rst           in   1                reset, synchronous, active-high
//  i_start         in   1                producer op accepted this cycle (convert unit o_start)
//  i_valid         in   1                result pulse from convert unit
//  i_fp_result     in   FP_WIDTH_D       FP result
//  i_int_result    in   XLEN             integer result
//  i_is_fp_to_int  in   1                1: route to int WB, 0: route to FP WB
//  i_flags         in   fp_flags_t(5)    exception flags {NV,DZ,OF,UF,NX}
//  i_dest_reg      in   5                destination register
//  i_flush         in   1                pipeline flush: discard buffered and in-flight results
//  o_hold          out  1                producer must not start a new op (gate its can_start)
//  o_int_wb_valid  out  1                head entry targets int regfile
//  i_int_wb_ready  in   1                int WB accepts
//  o_int_wb_data   out  XLEN             head int data
//  o_fp_wb_valid   out  1                head entry targets FP regfile
//  i_fp_wb_ready   in   1                FP WB accepts
//  o_fp_wb_data    out  FP_WIDTH_D       head FP data
//  o_wb_rd         out  5                head destination register
//  o_fflags_valid  out  1                pulse: an entry retired this cycle
//  o_fflags        out  5                flags of retiring entry (0 when o_fflags_valid=0)
//  o_count         out  $clog2(DEPTH)+1  buffered entries
//  o_overflow      out  1                sticky error: push to full buffer without pop
// BEHAVIOUR
//  - Reset: buffer empty, pointers 0, inflight=0, drop_next=0; all valids, o_hold, o_overflow,
//    o_fflags, o_count = 0.
//  - Push on i_valid (unless discarded, below); entry visible at head the next cycle (1-cycle latency).
//  - Head routing: exactly one of o_int_wb_valid/o_fp_wb_valid when non-empty, by is_fp_to_int.
//    Data/rd driven from head storage; valids 0 when empty. Strict in-order retire.
//  - Pop when the selected valid & its ready; int entry with rd==0 self-retires (no valid raised),
//    still pulses o_fflags_valid with its flags.
//  - Push and pop same cycle: count unchanged, permitted even when full.
//  - inflight: set on i_start, cleared on i_valid (same-cycle both: stays set).
//  - o_hold = (count + inflight) >= DEPTH, registered-free combinational from state.
//  - Full & push & no pop: entry dropped, o_overflow sets until reset (assertion in bench).
//  - i_flush: next cycle buffer empty, inflight=0; no retire or fflags pulse in flush cycle.
//    If inflight=1 and no i_valid in flush cycle, drop_next=1: next i_valid discarded, then clear.
//    i_valid in flush cycle itself is discarded. i_start in flush cycle is ignored.
//  - Pointer wrap modulo DEPTH; count saturates by construction at DEPTH.
// STRUCTURE
//  - riscv_pkg: fp_flags_t (existing); add cvt_result_entry_t {fp, int, is_fp_to_int, flags, rd}.
//  - One sub-module: fpu_result_fifo (param DEPTH, entry type; push/pop/flush/count/full/empty).
//    Top holds inflight/drop_next tracking, routing, fflags pulse.
// TESTING
//  - Single int cvt: i_start, then i_valid int=0x0000_0007 rd=5 flags=NX, ready=1 -> next cycle
//    o_int_wb_valid, data 7, rd 5, o_fflags=0x01 pulse, count returns 0.
//  - Stall: 2 FP results pushed, i_fp_wb_ready=0 -> count=2, o_hold=1; release -> in-order retire,
//    o_hold drops after first pop.
//  - Mixed routing: int result then FP result 0xFFFF_FFFF_3F80_0000, both readies=1 -> int port first,
//    FP port next cycle; never both valids together.
//  - rd==0 int result flags=NV -> no o_int_wb_valid, o_fflags_valid pulses with 0x10.
//  - Flush with inflight=1 -> following i_valid discarded, count stays 0; subsequent op retires normally.
//  - Full (count=2, ready=0), force i_valid -> o_overflow=1 and stays set until i_rst.

Source files
------------

// File: rtl/fpu_cvt_result_retire_pkg.sv
// Shared types for the convert-unit result retire path.
// Holds the FP exception flag layout and one buffered convert result entry.
package fpu_cvt_result_retire_pkg;

    localparam int PKG_XLEN       = 32;
    localparam int PKG_FP_WIDTH_D = 64;

    // Exception flags, MSB first: {NV, DZ, OF, UF, NX}
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fp_flags_t;

    typedef struct packed {
        logic [PKG_FP_WIDTH_D-1:0] fp_data;
        logic [PKG_XLEN-1:0]       int_data;
        logic                      is_fp_to_int;
        fp_flags_t                 flags;
        logic [4:0]                rd;
    } cvt_result_entry_t;

    // An int-destined entry with rd==x0 retires without a writeback handshake
    function automatic logic is_self_retire(input cvt_result_entry_t e);
        return e.is_fp_to_int && (e.rd == 5'd0);
    endfunction

endpackage

// File: rtl/fpu_cvt_result_retire_fifo.sv
// In-order result buffer for the convert retire block.
// Push when full is accepted only alongside a pop; otherwise the entry is dropped.
module fpu_result_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  entry_t                   i_push_entry,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output entry_t                   o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; payload needs no reset because occupancy gates visibility
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

endmodule

// File: rtl/fpu_cvt_result_retire.sv
// Captures single-cycle convert results into an in-order buffer and retires them to the
// int or FP writeback port, reporting fflags and back-pressuring the producer via o_hold.
module fpu_cvt_result_retire
    import fpu_cvt_result_retire_pkg::*;
#(
    parameter int XLEN       = PKG_XLEN,
    parameter int FP_WIDTH_D = PKG_FP_WIDTH_D,
    parameter int DEPTH      = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_valid,
    input  logic [FP_WIDTH_D-1:0]      i_fp_result,
    input  logic [XLEN-1:0]            i_int_result,
    input  logic                       i_is_fp_to_int,
    input  fp_flags_t                  i_flags,
    input  logic [4:0]                 i_dest_reg,
    input  logic                       i_flush,
    output logic                       o_hold,
    output logic                       o_int_wb_valid,
    input  logic                       i_int_wb_ready,
    output logic [XLEN-1:0]            o_int_wb_data,
    output logic                       o_fp_wb_valid,
    input  logic                       i_fp_wb_ready,
    output logic [FP_WIDTH_D-1:0]      o_fp_wb_data,
    output logic [4:0]                 o_wb_rd,
    output logic                       o_fflags_valid,
    output logic [4:0]                 o_fflags,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic               r_inflight;
    logic               r_drop_next;
    logic               r_overflow;
    cvt_result_entry_t  w_push_entry;
    cvt_result_entry_t  w_head;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_occupancy;
    logic               w_int_valid;
    logic               w_fp_valid;

    assign w_push_entry.fp_data      = i_fp_result;
    assign w_push_entry.int_data     = i_int_result;
    assign w_push_entry.is_fp_to_int = i_is_fp_to_int;
    assign w_push_entry.flags        = i_flags;
    assign w_push_entry.rd           = i_dest_reg;

    // Results arriving during a flush, or the stale result of a flushed op, never enter the buffer
    assign w_push = i_valid & ~i_flush & ~r_drop_next;

    fpu_result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (cvt_result_entry_t)
    ) u_fifo (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .i_flush      (i_flush),
        .o_head       (w_head),
        .o_count      (w_count),
        .o_full       (w_full),
        .o_empty      (w_empty)
    );

    // Head routing and retire decision; nothing retires in a flush cycle
    always_comb begin
        w_int_valid = 1'b0;
        w_fp_valid  = 1'b0;
        w_pop       = 1'b0;
        if (!w_empty && !i_flush) begin
            if (is_self_retire(w_head)) begin
                w_pop = 1'b1;
            end else if (w_head.is_fp_to_int) begin
                w_int_valid = 1'b1;
                w_pop       = i_int_wb_ready;
            end else begin
                w_fp_valid = 1'b1;
                w_pop      = i_fp_wb_ready;
            end
        end else begin
            w_pop = 1'b0;
        end
    end

    // Outstanding-op and post-flush discard tracking, plus the sticky overflow error
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_inflight  <= 1'b0;
            r_drop_next <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (i_flush) begin
                r_inflight  <= 1'b0;
                r_drop_next <= (r_drop_next | r_inflight) & ~i_valid;
            end else begin
                if (i_start) begin
                    r_inflight <= 1'b1;
                end else if (i_valid) begin
                    r_inflight <= 1'b0;
                end else begin
                    r_inflight <= r_inflight;
                end
                if (i_valid) begin
                    r_drop_next <= 1'b0;
                end else begin
                    r_drop_next <= r_drop_next;
                end
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else begin
                r_overflow <= r_overflow;
            end
        end
    end

    // An outstanding op reserves a slot so its unstallable result always has room
    assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign o_hold      = (w_occupancy >= (CW+1)'(DEPTH));

    assign o_int_wb_valid = w_int_valid;
    assign o_int_wb_data  = w_head.int_data;
    assign o_fp_wb_valid  = w_fp_valid;
    assign o_fp_wb_data   = w_head.fp_data;
    assign o_wb_rd        = w_head.rd;
    assign o_fflags_valid = w_pop;
    assign o_fflags       = w_pop ? w_head.flags : 5'd0;
    assign o_count        = w_count;
    assign o_overflow     = r_overflow;

endmodule

// File: tb/tb_fpu_cvt_result_retire.sv
// Directed table-driven bench for fpu_cvt_result_retire: one vector per clock cycle,
// outputs compared mid-cycle after the inputs for that cycle have settled.
module tb_fpu_cvt_result_retire;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start, i_valid, i_is_fp_to_int, i_flush;
    logic [63:0] i_fp_result;
    logic [31:0] i_int_result;
    logic [4:0]  i_flags, i_dest_reg;
    logic        o_hold, o_int_wb_valid, i_int_wb_ready, o_fp_wb_valid, i_fp_wb_ready;
    logic [31:0] o_int_wb_data;
    logic [63:0] o_fp_wb_data;
    logic [4:0]  o_wb_rd, o_fflags;
    logic        o_fflags_valid, o_overflow;
    logic [1:0]  o_count;

    int total = 0;
    int bad   = 0;
    int cur   = 0;

    always #5 i_clk = ~i_clk;

    fpu_cvt_result_retire #(.XLEN(32), .FP_WIDTH_D(64), .DEPTH(2)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid),
        .i_fp_result(i_fp_result), .i_int_result(i_int_result), .i_is_fp_to_int(i_is_fp_to_int),
        .i_flags(i_flags), .i_dest_reg(i_dest_reg), .i_flush(i_flush), .o_hold(o_hold),
        .o_int_wb_valid(o_int_wb_valid), .i_int_wb_ready(i_int_wb_ready), .o_int_wb_data(o_int_wb_data),
        .o_fp_wb_valid(o_fp_wb_valid), .i_fp_wb_ready(i_fp_wb_ready), .o_fp_wb_data(o_fp_wb_data),
        .o_wb_rd(o_wb_rd), .o_fflags_valid(o_fflags_valid), .o_fflags(o_fflags),
        .o_count(o_count), .o_overflow(o_overflow)
    );

    typedef struct packed {
        logic st, vl, fl, f2i;
        logic [4:0]  flags, rd;
        logic [31:0] idat;
        logic [63:0] fdat;
        logic ir, fr;
        logic e_iv, e_fv;
        logic [4:0]  e_rd;
        logic [31:0] e_idat;
        logic [63:0] e_fdat;
        logic e_ffv;
        logic [4:0]  e_ff;
        logic [1:0]  e_cnt;
        logic e_hold, e_ovf;
    } vec_t;

    vec_t tbl[$];

    localparam logic [63:0] FP_A = 64'h4000_0000_0000_0000;
    localparam logic [63:0] FP_B = 64'h4008_0000_0000_0000;
    localparam logic [63:0] FP_S = 64'hFFFF_FFFF_3F80_0000;

    function automatic vec_t mk(
        input logic st, vl, fl, f2i, input logic [4:0] flags, rd, input logic [31:0] idat,
        input logic [63:0] fdat, input logic ir, fr, input logic e_iv, e_fv, input logic [4:0] e_rd,
        input logic [31:0] e_idat, input logic [63:0] e_fdat, input logic e_ffv, input logic [4:0] e_ff,
        input logic [1:0] e_cnt, input logic e_hold, e_ovf);
        vec_t v;
        v.st = st; v.vl = vl; v.fl = fl; v.f2i = f2i; v.flags = flags; v.rd = rd;
        v.idat = idat; v.fdat = fdat; v.ir = ir; v.fr = fr;
        v.e_iv = e_iv; v.e_fv = e_fv; v.e_rd = e_rd; v.e_idat = e_idat; v.e_fdat = e_fdat;
        v.e_ffv = e_ffv; v.e_ff = e_ff; v.e_cnt = e_cnt; v.e_hold = e_hold; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s vec%0d: got %0h, want %0h", name, cur, got, exp);
        end
    endtask

    task automatic run(input vec_t v);
        @(negedge i_clk);
        i_start = v.st; i_valid = v.vl; i_flush = v.fl; i_is_fp_to_int = v.f2i;
        i_flags = v.flags; i_dest_reg = v.rd; i_int_result = v.idat; i_fp_result = v.fdat;
        i_int_wb_ready = v.ir; i_fp_wb_ready = v.fr;
        #2;
        cmp("int_valid", {63'd0, o_int_wb_valid}, {63'd0, v.e_iv});
        cmp("fp_valid", {63'd0, o_fp_wb_valid}, {63'd0, v.e_fv});
        cmp("fflags_valid", {63'd0, o_fflags_valid}, {63'd0, v.e_ffv});
        cmp("fflags", {59'd0, o_fflags}, {59'd0, v.e_ff});
        cmp("count", {62'd0, o_count}, {62'd0, v.e_cnt});
        cmp("hold", {63'd0, o_hold}, {63'd0, v.e_hold});
        cmp("overflow", {63'd0, o_overflow}, {63'd0, v.e_ovf});
        if (v.e_iv || v.e_fv) cmp("wb_rd", {59'd0, o_wb_rd}, {59'd0, v.e_rd});
        if (v.e_iv) cmp("int_data", {32'd0, o_int_wb_data}, {32'd0, v.e_idat});
        if (v.e_fv) cmp("fp_data", o_fp_wb_data, v.e_fdat);
        cur++;
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_is_fp_to_int = 1'b0;
        i_flags = 5'd0; i_dest_reg = 5'd0; i_int_result = 32'd0; i_fp_result = 64'd0;
        i_int_wb_ready = 1'b1; i_fp_wb_ready = 1'b1;

        // single int convert, rd=5, NX
        tbl.push_back(mk(1,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,1,5'h01, 5'd5,32'h7,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 1,0,5'd5,32'h7,64'h0,1,5'h01,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // FP stall then in-order release
        tbl.push_back(mk(0,1,0,0,5'h00, 5'd1,32'h0,FP_A,1,0, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,0,5'h04, 5'd2,32'h0,FP_B,1,0, 0,1,5'd1,32'h0,FP_A,0,5'h00,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,0, 0,1,5'd1,32'h0,FP_A,0,5'h00,2'd2,1,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,1,5'd1,32'h0,FP_A,1,5'h00,2'd2,1,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,1,5'd2,32'h0,FP_B,1,5'h04,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // mixed routing: int then NaN-boxed single
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd3,32'h1234_5678,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,0,5'h01, 5'd4,32'h0,FP_S,1,1, 1,0,5'd3,32'h1234_5678,64'h0,1,5'h00,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,1,5'd4,32'h0,FP_S,1,5'h01,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // rd==0 int result self-retires, NV
        tbl.push_back(mk(0,1,0,1,5'h10, 5'd0,32'hDEAD,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,1,5'h10,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // flush with inflight: next result discarded, following op retires
        tbl.push_back(mk(1,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,0,1,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,1,5'h01, 5'd6,32'h55,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(1,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd7,32'h66,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 1,0,5'd7,32'h66,64'h0,1,5'h00,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // flush with buffered entry and a result in the flush cycle
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd8,32'h11,64'h0,0,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,1,1,5'h00, 5'd9,32'h22,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd1,0,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        // full: push+pop allowed, then push without pop overflows
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd10,32'hA,64'h0,0,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd11,32'hB,64'h0,0,1, 1,0,5'd10,32'hA,64'h0,0,5'h00,2'd1,0,0));
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd13,32'hD,64'h0,1,1, 1,0,5'd10,32'hA,64'h0,1,5'h00,2'd2,1,0));
        tbl.push_back(mk(0,1,0,1,5'h00, 5'd12,32'hC,64'h0,0,1, 1,0,5'd11,32'hB,64'h0,0,5'h00,2'd2,1,0));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,0,1, 1,0,5'd11,32'hB,64'h0,0,5'h00,2'd2,1,1));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 1,0,5'd11,32'hB,64'h0,1,5'h00,2'd2,1,1));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 1,0,5'd13,32'hD,64'h0,1,5'h00,2'd1,0,1));
        tbl.push_back(mk(0,0,0,0,5'h00, 5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,1));

        // reset state, sampled while reset is still asserted
        repeat (2) @(negedge i_clk);
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        i_rst = 1'b0;

        foreach (tbl[k]) run(tbl[k]);

        // overflow is sticky until reset
        @(negedge i_clk); i_rst = 1'b1;
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        i_rst = 1'b0;
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));

        // hold from one buffered entry plus an outstanding op; start ignored during flush
        run(mk(1,1,0,1,5'h00,5'd1,32'h77,64'h0,0,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,0,1, 1,0,5'd1,32'h77,64'h0,0,5'h00,2'd1,1,0));
        run(mk(0,1,0,1,5'h00,5'd2,32'h78,64'h0,0,1, 1,0,5'd1,32'h77,64'h0,0,5'h00,2'd1,1,0));
        run(mk(1,0,1,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd2,1,0));
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));

        // flush cycle carrying the inflight result: nothing left to discard afterwards
        run(mk(1,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        run(mk(0,1,1,1,5'h00,5'd3,32'h99,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        run(mk(0,1,0,1,5'h02,5'd4,32'h9A,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 1,0,5'd4,32'h9A,64'h0,1,5'h02,2'd1,0,0));
        run(mk(0,0,0,0,5'h00,5'd0,32'h0,64'h0,1,1, 0,0,5'd0,32'h0,64'h0,0,5'h00,2'd0,0,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
